// File: rtl/stream_upsize_arbiter.sv
// Packet-granular round-robin arbiter that feeds one stream_upsize input from N narrow sources.
// The grant is held from the first beat through the last beat so that sources never mix inside an upsized word.
module stream_upsize_arbiter #(
    parameter int T_DATA_WIDTH = 8,
    parameter int N_SOURCES    = 4,
    parameter int ID_WIDTH     = $clog2(N_SOURCES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [N_SOURCES],
    input  logic [N_SOURCES-1:0]    s_last_i,
    input  logic [N_SOURCES-1:0]    s_valid_i,
    output logic [N_SOURCES-1:0]    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [ID_WIDTH-1:0]     m_id_o,
    output logic                    busy_o
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ID_WIDTH-1:0] grant_r;
    logic [ID_WIDTH-1:0] rr_ptr_r;
    logic [ID_WIDTH-1:0] pick_s;
    logic                pick_vld_s;
    logic                xfer_s;
    logic                pkt_done_s;

    assign xfer_s     = (state_r == LOCKED) & s_valid_i[grant_r] & m_ready_i;
    assign pkt_done_s = xfer_s & s_last_i[grant_r];

    // Round-robin search: first valid source after rr_ptr, wrapping modulo N_SOURCES
    always_comb begin
        pick_s     = {ID_WIDTH{1'b0}};
        pick_vld_s = 1'b0;
        for (int k = 1; k <= N_SOURCES; k++) begin
            if (!pick_vld_s && s_valid_i[ID_WIDTH'((int'(rr_ptr_r) + k) % N_SOURCES)]) begin
                pick_s     = ID_WIDTH'((int'(rr_ptr_r) + k) % N_SOURCES);
                pick_vld_s = 1'b1;
            end else begin
                pick_s     = pick_s;
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant and round-robin pointer; source 0 gets first priority out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r  <= {ID_WIDTH{1'b0}};
            rr_ptr_r <= ID_WIDTH'(N_SOURCES - 1);
        end else begin
            if ((state_r == IDLE) && pick_vld_s) begin
                grant_r <= pick_s;
            end else begin
                grant_r <= grant_r;
            end
            if (pkt_done_s) begin
                rr_ptr_r <= grant_r;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Next-state logic: lock on a winner, release after the accepted last beat
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_vld_s) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (pkt_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output logic: unbuffered mux of the granted source while locked, all quiet in IDLE
    always_comb begin
        s_ready_o = {N_SOURCES{1'b0}};
        m_data_o  = {T_DATA_WIDTH{1'b0}};
        m_last_o  = 1'b0;
        m_valid_o = 1'b0;
        case (state_r)
            IDLE: begin
                s_ready_o = {N_SOURCES{1'b0}};
                m_valid_o = 1'b0;
            end
            LOCKED: begin
                m_data_o           = s_data_i[grant_r];
                m_last_o           = s_last_i[grant_r];
                m_valid_o          = s_valid_i[grant_r];
                s_ready_o[grant_r] = m_ready_i;
            end
            default: begin
                s_ready_o = {N_SOURCES{1'b0}};
                m_valid_o = 1'b0;
            end
        endcase
        m_id_o = grant_r;
        busy_o = (state_r == LOCKED);
    end

endmodule
